// File: rtl/dbuf_swap_ctrl.sv
// Double-buffer swap controller for the 640x480 2-bit frame memory.
// Flips the buffer select only at vertical-blank start after the rasterizer finishes a frame,
// gates drawing while a swap is pending, and optionally sweeps the new back buffer clear.
// Optional feature macro: DBUF_CLEAR_ON_SWAP_EN (defined = clear sweep after every swap).
module dbuf_swap_ctrl #(
    parameter int unsigned     FRAME_PIXELS = 307200,
    parameter int unsigned     ADDR_W       = 19,
    parameter int unsigned     CLR_W        = 2,
    parameter logic [CLR_W-1:0] CLR_COLOR   = '0,
    parameter int unsigned     CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frame_done_i,
    input  logic              vblank_start_i,
    output logic              swap_o,
    output logic              draw_en_o,
    output logic              swap_ack_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic [CLR_W-1:0]  clr_data_o,
    output logic              clr_busy_o
);

    // The sweep must fit in the buffer-local address space.
    if (FRAME_PIXELS == 0 || FRAME_PIXELS > (2 ** ADDR_W)) begin : g_bad_cfg
        $error("FRAME_PIXELS does not fit in ADDR_W");
    end

    typedef enum logic [1:0] {
        StDraw,
        StWaitVb
`ifdef DBUF_CLEAR_ON_SWAP_EN
        ,StClear
`endif
    } state_e;

    state_e             state_q, state_d;
    logic               swap_q, swap_d;
    logic               draw_en_q, draw_en_d;
    logic               swap_ack_q, swap_ack_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

`ifdef DBUF_CLEAR_ON_SWAP_EN
    logic               clr_we_q, clr_we_d;
    logic               clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
`endif

    // Next-state logic: handshake sequencing, swap toggle and clear sweep.
    always_comb begin
        state_d     = state_q;
        swap_d      = swap_q;
        draw_en_d   = draw_en_q;
        swap_ack_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
`ifdef DBUF_CLEAR_ON_SWAP_EN
        clr_we_d    = clr_we_q;
        clr_busy_d  = clr_busy_q;
        clr_addr_d  = clr_addr_q;
`endif
        case (state_q)
            StDraw: begin
                // A pixel written alongside frame_done is still accepted; gating starts next cycle.
                draw_en_d = 1'b1;
                if (frame_done_i) begin
                    state_d   = StWaitVb;
                    draw_en_d = 1'b0;
                end
            end
            StWaitVb: begin
                draw_en_d = 1'b0;
                if (vblank_start_i) begin
                    swap_d      = ~swap_q;
                    swap_ack_d  = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
`ifdef DBUF_CLEAR_ON_SWAP_EN
                    state_d     = StClear;
                    clr_busy_d  = 1'b1;
                    clr_addr_d  = '0;
`else
                    state_d     = StDraw;
`endif
                end
            end
`ifdef DBUF_CLEAR_ON_SWAP_EN
            StClear: begin
                // First CLEAR cycle only arms the strobe; address advances once writes are live.
                draw_en_d  = 1'b0;
                clr_busy_d = 1'b1;
                clr_we_d   = 1'b1;
                if (clr_we_q) begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
                if (clr_we_q && clr_addr_q == ADDR_W'(FRAME_PIXELS - 1)) begin
                    clr_we_d   = 1'b0;
                    clr_busy_d = 1'b0;
                    clr_addr_d = '0;
                    draw_en_d  = 1'b1;
                    state_d    = StDraw;
                end
            end
`endif
            default: begin
                state_d   = StDraw;
                draw_en_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset abandons any wait or partial sweep.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StDraw;
            swap_q      <= 1'b0;
            draw_en_q   <= 1'b1;
            swap_ack_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            swap_q      <= swap_d;
            draw_en_q   <= draw_en_d;
            swap_ack_q  <= swap_ack_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef DBUF_CLEAR_ON_SWAP_EN
    // Clear-sweep registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clr_we_q   <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            clr_we_q   <= clr_we_d;
            clr_busy_q <= clr_busy_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign clr_we_o   = clr_we_q;
    assign clr_busy_o = clr_busy_q;
    assign clr_addr_o = clr_addr_q;
`else
    assign clr_we_o   = 1'b0;
    assign clr_busy_o = 1'b0;
    assign clr_addr_o = '0;
`endif

    assign swap_o      = swap_q;
    assign draw_en_o   = draw_en_q;
    assign swap_ack_o  = swap_ack_q;
    assign frame_cnt_o = frame_cnt_q;
    assign clr_data_o  = CLR_COLOR;

endmodule

// File: tb/tb_dbuf_swap_ctrl.sv
// Directed bench for dbuf_swap_ctrl (small frame and 2-bit counter to reach the corners quickly).
module tb_dbuf_swap_ctrl;

    localparam int unsigned FP     = 16;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned CLR_W  = 2;
    localparam int unsigned CNT_W  = 2;
    localparam logic [CLR_W-1:0] CLR_COLOR = 2'b00;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              frame_done_i = 1'b0;
    logic              vblank_start_i = 1'b0;
    logic              swap_o;
    logic              draw_en_o;
    logic              swap_ack_o;
    logic [CNT_W-1:0]  frame_cnt_o;
    logic              clr_we_o;
    logic [ADDR_W-1:0] clr_addr_o;
    logic [CLR_W-1:0]  clr_data_o;
    logic              clr_busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    dbuf_swap_ctrl #(
        .FRAME_PIXELS (FP),
        .ADDR_W       (ADDR_W),
        .CLR_W        (CLR_W),
        .CLR_COLOR    (CLR_COLOR),
        .CNT_W        (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .frame_done_i   (frame_done_i),
        .vblank_start_i (vblank_start_i),
        .swap_o         (swap_o),
        .draw_en_o      (draw_en_o),
        .swap_ack_o     (swap_ack_o),
        .frame_cnt_o    (frame_cnt_o),
        .clr_we_o       (clr_we_o),
        .clr_addr_o     (clr_addr_o),
        .clr_data_o     (clr_data_o),
        .clr_busy_o     (clr_busy_o)
    );

    always #5 clk_i = ~clk_i;

    // One clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        frame_done_i = 1'b0;
        vblank_start_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic pulse_fd();
        frame_done_i = 1'b1;
        step();
        frame_done_i = 1'b0;
    endtask

    task automatic pulse_vb();
        vblank_start_i = 1'b1;
        step();
        vblank_start_i = 1'b0;
    endtask

`ifdef DBUF_CLEAR_ON_SWAP_EN
    localparam int unsigned SettleCycles = FP + 4;
`else
    localparam int unsigned SettleCycles = 4;
`endif

    task automatic test_reset();
        int changes;
        apply_reset();
        // Get swap/frame_cnt away from reset values, then assert rst between edges.
        pulse_fd();
        step(3);
        pulse_vb();
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({swap_o, draw_en_o, swap_ack_o, frame_cnt_o, clr_we_o, clr_busy_o, clr_addr_o} !==
            {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 19'd0}) begin
            n_fail++;
            $display("FAIL reset_async: swap=%b draw_en=%b ack=%b cnt=%0d we=%b busy=%b addr=%0d, want 0 1 0 0 0 0 0",
                     swap_o, draw_en_o, swap_ack_o, frame_cnt_o, clr_we_o, clr_busy_o, clr_addr_o);
        end
        step();
        rst_i = 1'b0;
        changes = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if ({swap_o, draw_en_o, swap_ack_o, frame_cnt_o, clr_we_o, clr_busy_o} !==
                {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0}) changes++;
        end
        n_checks++;
        if (changes !== 0) begin
            n_fail++;
            $display("FAIL reset_idle: %0d cycles with changed outputs, want 0", changes);
        end
        n_checks++;
        if (clr_data_o !== CLR_COLOR) begin
            n_fail++;
            $display("FAIL clr_data: got %b want %b", clr_data_o, CLR_COLOR);
        end
    endtask

    task automatic test_handshake();
        apply_reset();
        step(9);
        pulse_fd();
        n_checks++;
        if (draw_en_o !== 1'b0 || swap_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_gate: draw_en=%b swap=%b want 0 0", draw_en_o, swap_o);
        end
        step(39);
        pulse_vb();
        n_checks++;
        if ({swap_o, swap_ack_o, frame_cnt_o, draw_en_o} !== {1'b1, 1'b1, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL hs_swap: swap=%b ack=%b cnt=%0d draw_en=%b want 1 1 1 0",
                     swap_o, swap_ack_o, frame_cnt_o, draw_en_o);
        end
        step();
        n_checks++;
`ifdef DBUF_CLEAR_ON_SWAP_EN
        if (swap_ack_o !== 1'b0 || draw_en_o !== 1'b0 || swap_o !== 1'b1) begin
`else
        if (swap_ack_o !== 1'b0 || draw_en_o !== 1'b1 || swap_o !== 1'b1) begin
`endif
            n_fail++;
            $display("FAIL hs_after: ack=%b draw_en=%b swap=%b", swap_ack_o, draw_en_o, swap_o);
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        frame_done_i = 1'b1;
        vblank_start_i = 1'b1;
        step();
        frame_done_i = 1'b0;
        vblank_start_i = 1'b0;
        n_checks++;
        if ({swap_o, swap_ack_o, draw_en_o, frame_cnt_o} !== {1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL same_cycle_noswap: swap=%b ack=%b draw_en=%b cnt=%0d want 0 0 0 0",
                     swap_o, swap_ack_o, draw_en_o, frame_cnt_o);
        end
        step(78);
        pulse_vb();
        n_checks++;
        if ({swap_o, swap_ack_o, frame_cnt_o} !== {1'b1, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL same_cycle_next_vb: swap=%b ack=%b cnt=%0d want 1 1 1",
                     swap_o, swap_ack_o, frame_cnt_o);
        end
    endtask

    task automatic test_missed_frame();
        int acks;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(5);
            pulse_vb();
            n_checks++;
            if ({swap_o, swap_ack_o, frame_cnt_o, draw_en_o} !== {1'b0, 1'b0, 2'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL missed_vb%0d: swap=%b ack=%b cnt=%0d draw_en=%b want 0 0 0 1",
                         i, swap_o, swap_ack_o, frame_cnt_o, draw_en_o);
            end
        end
        pulse_fd();
        step(2);
        pulse_fd();
        step(2);
        pulse_fd();
        acks = 0;
        pulse_vb();
        if (swap_ack_o === 1'b1) acks++;
        // Further vblanks with no new frame_done must not swap again.
        for (int i = 0; i < 40; i++) begin
            vblank_start_i = (i % 8 == 7);
            step();
            if (swap_ack_o === 1'b1) acks++;
        end
        vblank_start_i = 1'b0;
        n_checks++;
        if (acks !== 1 || swap_o !== 1'b1 || frame_cnt_o !== 2'd1) begin
            n_fail++;
            $display("FAIL missed_one_swap: acks=%0d swap=%b cnt=%0d want 1 1 1",
                     acks, swap_o, frame_cnt_o);
        end
    endtask

    task automatic test_wrap();
        logic [CNT_W-1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1;
        exp_cnt[1] = 2'd2;
        exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd0;
        exp_cnt[4] = 2'd1;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            pulse_fd();
            step(2);
            pulse_vb();
            n_checks++;
            if (frame_cnt_o !== exp_cnt[i] || swap_o !== ((i % 2) == 0) || swap_ack_o !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_%0d: cnt=%0d swap=%b ack=%b want %0d %0d 1",
                         i, frame_cnt_o, swap_o, swap_ack_o, exp_cnt[i], (i % 2) == 0);
            end
            step(SettleCycles);
        end
    endtask

`ifdef DBUF_CLEAR_ON_SWAP_EN
    task automatic test_clear();
        int bad;
        apply_reset();
        pulse_fd();
        step(2);
        pulse_vb();
        bad = 0;
        for (int k = 0; k < FP; k++) begin
            step();
            if (clr_we_o !== 1'b1 || clr_addr_o !== ADDR_W'(k) || clr_busy_o !== 1'b1 ||
                draw_en_o !== 1'b0 || clr_data_o !== CLR_COLOR) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL clear_sweep: %0d bad cycles, want 0", bad);
        end
        step();
        n_checks++;
        if ({clr_we_o, clr_busy_o, draw_en_o} !== 3'b001 || clr_addr_o !== '0) begin
            n_fail++;
            $display("FAIL clear_end: we=%b busy=%b draw_en=%b addr=%0d want 0 0 1 0",
                     clr_we_o, clr_busy_o, draw_en_o, clr_addr_o);
        end
        pulse_fd();
        step(2);
        pulse_vb();
        step(8);
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({clr_we_o, clr_busy_o, swap_o} !== 3'b000 || clr_addr_o !== '0) begin
            n_fail++;
            $display("FAIL clear_reset: we=%b busy=%b swap=%b addr=%0d want 0 0 0 0",
                     clr_we_o, clr_busy_o, swap_o, clr_addr_o);
        end
        step();
        rst_i = 1'b0;
    endtask
`else
    task automatic test_clear();
        int bad;
        apply_reset();
        pulse_fd();
        step(2);
        pulse_vb();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (clr_we_o !== 1'b0 || clr_busy_o !== 1'b0 || clr_addr_o !== '0 ||
                clr_data_o !== CLR_COLOR) bad++;
            step();
        end
        n_checks++;
        if (bad !== 0 || draw_en_o !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_absent: %0d bad cycles draw_en=%b, want 0 1", bad, draw_en_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_handshake();
        test_same_cycle();
        test_missed_frame();
        test_wrap();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
